// File: rtl/gen_gamma_pkg.sv
// Shared types and defaults for the gamma encoder.
//   gg_state_t  : encoder control state (IDLE, KEYED, RUN)
//   GG_SIZE_DEF : default plaintext / gamma width
package gen_gamma_pkg;

  localparam int unsigned GG_SIZE_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    KEYED = 2'd1,
    RUN   = 2'd2
  } gg_state_t;

endpackage

// File: rtl/gen_gamma_core.sv
// Key and gamma registers with the gamma-step adder.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : latch nk into both key and gamma (takes priority over step)
//   step       : advance gamma by the key, mod 2^SIZE
//   nk         : key input, sampled only on load
//   gamma      : current gamma value
module gen_gamma_core
  import gen_gamma_pkg::*;
#(
  parameter int unsigned SIZE = GG_SIZE_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step,
  input  logic [SIZE-1:0] nk,
  output logic [SIZE-1:0] gamma
);

  logic [SIZE-1:0] key_q;
  logic [SIZE-1:0] gamma_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q   <= '0;
      gamma_q <= '0;
    end else if (load) begin
      key_q   <= nk;
      gamma_q <= nk;
    end else if (step) begin
      gamma_q <= gamma_q + key_q;
    end
  end

  assign gamma = gamma_q;

endmodule

// File: rtl/gen_gamma_encoder.sv
// Gamma stream encoder: md = pd + gamma as a SIZE+1 bit sum, gamma advancing
// by the key after every accepted word.
//   clk, rst_n         : clock, asynchronous active-low reset
//   set0, set1         : key load / run enable (set0 has priority)
//   nk                 : key, sampled while set0=1
//   pd, pd_valid       : plaintext input, pd_ready is combinational
//   md, md_valid       : registered ciphertext output, md_ready from downstream
//   wcnt               : words accepted since the last key load
module gen_gamma_encoder
  import gen_gamma_pkg::*;
#(
  parameter int unsigned SIZE = GG_SIZE_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            set0,
  input  logic            set1,
  input  logic [SIZE-1:0] nk,
  input  logic [SIZE-1:0] pd,
  input  logic            pd_valid,
  output logic            pd_ready,
  output logic [SIZE:0]   md,
  output logic            md_valid,
  input  logic            md_ready,
  output logic [SIZE-1:0] wcnt
);

  localparam logic [SIZE-1:0] WCNT_ONE = SIZE'(1);

  gg_state_t       state_q;
  logic [SIZE:0]   md_q;
  logic            md_valid_q;
  logic [SIZE-1:0] wcnt_q;
  logic [SIZE-1:0] gamma;
  logic [SIZE:0]   sum;
  logic            accept;

  // A key load on the same edge as a handshake discards the word.
  assign pd_ready = (state_q == RUN) && (!md_valid_q || md_ready);
  assign accept   = pd_valid && pd_ready && !set0;
  assign sum      = {1'b0, pd} + {1'b0, gamma};

  gen_gamma_core #(
    .SIZE (SIZE)
  ) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (set0),
    .step  (accept),
    .nk    (nk),
    .gamma (gamma)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      md_q       <= '0;
      md_valid_q <= 1'b0;
      wcnt_q     <= '0;
    end else if (set0) begin
      state_q    <= KEYED;
      md_valid_q <= 1'b0;
      wcnt_q     <= '0;
    end else begin
      if (accept) begin
        md_q       <= sum;
        md_valid_q <= 1'b1;
        wcnt_q     <= wcnt_q + WCNT_ONE;
      end else if (md_valid_q && md_ready) begin
        md_valid_q <= 1'b0;
      end
      case (state_q)
        KEYED:   if (set1) state_q <= RUN;
        RUN:     if (!set1) state_q <= KEYED;
        default: state_q <= state_q;
      endcase
    end
  end

  assign md       = md_q;
  assign md_valid = md_valid_q;
  assign wcnt     = wcnt_q;

endmodule

// File: tb/tb_gen_gamma_encoder.sv
module tb_gen_gamma_encoder;

  localparam int SIZE = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            set0 = 1'b0;
  logic            set1 = 1'b0;
  logic [SIZE-1:0] nk = '0;
  logic [SIZE-1:0] pd = '0;
  logic            pd_valid = 1'b0;
  logic            pd_ready;
  logic [SIZE:0]   md;
  logic            md_valid;
  logic            md_ready = 1'b0;
  logic [SIZE-1:0] wcnt;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: mode 0=idle, 1=keyed, 2=run; gamma derived from word count.
  int m_mode = 0;
  int m_key  = 0;
  int m_cnt  = 0;
  int m_mdv  = 0;
  int m_md   = 0;

  gen_gamma_encoder #(
    .SIZE (SIZE)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .set0     (set0),
    .set1     (set1),
    .nk       (nk),
    .pd       (pd),
    .pd_valid (pd_valid),
    .pd_ready (pd_ready),
    .md       (md),
    .md_valid (md_valid),
    .md_ready (md_ready),
    .wcnt     (wcnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int model_gamma();
    return ((m_cnt + 1) * m_key) % 256;
  endfunction

  function automatic int model_ready();
    return (m_mode == 2 && (m_mdv == 0 || md_ready)) ? 1 : 0;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_key = 0; m_cnt = 0; m_mdv = 0; m_md = 0;
  endtask

  // Apply one cycle of inputs (called at negedge), check pd_ready, clock, check outputs.
  task automatic cycle(input bit s0, input bit s1, input int k, input int p,
                       input bit pv, input bit mr);
    int rdy;
    set0 = s0; set1 = s1; nk = k[7:0]; pd = p[7:0]; pd_valid = pv; md_ready = mr;
    #1;
    rdy = model_ready();
    check_eq("pd_ready", {31'b0, pd_ready}, rdy);
    @(posedge clk);
    if (s0) begin
      m_mode = 1; m_key = k & 255; m_cnt = 0; m_mdv = 0;
    end else begin
      if (rdy != 0 && pv) begin
        m_md  = (p & 255) + model_gamma();
        m_mdv = 1;
        m_cnt++;
      end else if (m_mdv != 0 && mr) begin
        m_mdv = 0;
      end
      if (m_mode == 1 && s1) m_mode = 2;
      else if (m_mode == 2 && !s1) m_mode = 1;
    end
    @(negedge clk);
    check_eq("md_valid", {31'b0, md_valid}, m_mdv);
    check_eq("md", {23'b0, md}, m_md);
    check_eq("wcnt", {24'b0, wcnt}, m_cnt % 256);
  endtask

  initial begin
    // Reset state, with pd_valid already high.
    pd_valid = 1'b1;
    #12;
    check_eq("rst_md_valid", {31'b0, md_valid}, 0);
    check_eq("rst_md", {23'b0, md}, 0);
    check_eq("rst_wcnt", {24'b0, wcnt}, 0);
    check_eq("rst_pd_ready", {31'b0, pd_ready}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    // IDLE never accepts, even with set1 high.
    cycle(0, 1, 8'h00, 8'h11, 1, 1);
    cycle(0, 1, 8'h00, 8'h22, 1, 1);
    check_eq("idle_no_accept", {31'b0, md_valid}, 0);

    // Basic sequence, nk=0x35.
    cycle(1, 0, 8'h35, 8'h00, 0, 1);
    cycle(0, 1, 8'h00, 8'h00, 0, 1);
    cycle(0, 1, 8'h00, 8'hF0, 1, 1);
    check_eq("w0_md", {23'b0, md}, 32'h125);
    cycle(0, 1, 8'h00, 8'h10, 1, 1);
    check_eq("w1_md", {23'b0, md}, 32'h07A);
    check_eq("w1_wcnt", {24'b0, wcnt}, 2);

    // Back-pressure.
    cycle(1, 1, 8'h35, 8'h00, 0, 1);
    cycle(0, 1, 8'h00, 8'h00, 0, 1);
    cycle(0, 1, 8'h00, 8'hF0, 1, 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 8'h00, 8'h10, 1, 0);
    check_eq("bp_md_hold", {23'b0, md}, 32'h125);
    check_eq("bp_pd_ready", {31'b0, pd_ready}, 0);
    cycle(0, 1, 8'h00, 8'h10, 0, 1);
    cycle(0, 1, 8'h00, 8'h10, 1, 1);
    check_eq("bp_next_md", {23'b0, md}, 32'h07A);

    // Gamma wrap, nk=0x80.
    cycle(1, 0, 8'h80, 8'h00, 0, 1);
    cycle(0, 1, 8'h00, 8'h00, 0, 1);
    cycle(0, 1, 8'h00, 8'hFF, 1, 1);
    check_eq("wrap0", {23'b0, md}, 32'h17F);
    cycle(0, 1, 8'h00, 8'hFF, 1, 1);
    check_eq("wrap1", {23'b0, md}, 32'h0FF);
    cycle(0, 1, 8'h00, 8'hFF, 1, 1);
    check_eq("wrap2", {23'b0, md}, 32'h17F);

    // Pause mid-stream and resume.
    cycle(1, 0, 8'h35, 8'h00, 0, 1);
    cycle(0, 1, 8'h00, 8'h00, 0, 1);
    cycle(0, 1, 8'h00, 8'h01, 1, 1);
    cycle(0, 0, 8'h00, 8'h02, 1, 1);
    cycle(0, 0, 8'h00, 8'h03, 1, 1);
    check_eq("pause_pd_ready", {31'b0, pd_ready}, 0);
    cycle(0, 1, 8'h00, 8'h03, 0, 1);
    cycle(0, 1, 8'h00, 8'h03, 1, 1);
    check_eq("resume_md", {23'b0, md}, 32'h03 + 32'h9F);

    // Rekey with set0 and set1 together while a word is pending.
    cycle(0, 1, 8'h00, 8'h04, 1, 0);
    cycle(1, 1, 8'h01, 8'h05, 1, 0);
    check_eq("rekey_md_valid", {31'b0, md_valid}, 0);
    check_eq("rekey_wcnt", {24'b0, wcnt}, 0);
    cycle(0, 1, 8'h00, 8'h20, 0, 1);
    cycle(0, 1, 8'h00, 8'h20, 1, 1);
    check_eq("rekey_md", {23'b0, md}, 32'h021);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      bit s0, s1, pv, mr;
      s0 = ($urandom_range(0, 19) == 0);
      s1 = ($urandom_range(0, 7) != 0);
      pv = ($urandom_range(0, 3) != 0);
      mr = ($urandom_range(0, 3) != 0);
      cycle(s0, s1, $urandom_range(0, 255), $urandom_range(0, 255), pv, mr);
    end

    // Asynchronous reset while a word is pending.
    cycle(1, 0, 8'h5A, 8'h00, 0, 0);
    cycle(0, 1, 8'h00, 8'h00, 0, 0);
    cycle(0, 1, 8'h00, 8'h77, 1, 0);
    check_eq("pre_rst_md_valid", {31'b0, md_valid}, 1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("arst_md_valid", {31'b0, md_valid}, 0);
    check_eq("arst_md", {23'b0, md}, 0);
    check_eq("arst_wcnt", {24'b0, wcnt}, 0);
    check_eq("arst_pd_ready", {31'b0, pd_ready}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(0, 1, 8'h00, 8'h33, 1, 1);
    cycle(0, 1, 8'h00, 8'h33, 1, 1);
    check_eq("arst_idle", {31'b0, pd_ready}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
